// File: rtl/neuro_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuro_cfg_sequencer
// Description : Runtime-configurable synapse/neuron sequencer. Validates a
//               configuration, builds the synapse map one synapse per cycle,
//               then gates synapse fire vectors into per-neuron response
//               vectors for a fixed number of timesteps.
//               Optional per-neuron spike counters: NEURO_SPIKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module neuro_cfg_sequencer #(
   parameter  int NUM_INPUTS  = 4,
   parameter  int NUM_SYNAPSE = 16,
   parameter  int NUM_NEURONS = 4,
   parameter  int TS_W        = 8,
   parameter  int CNT_W       = 8,
   localparam int IW          = $clog2(NUM_INPUTS) + 1,
   localparam int NW          = $clog2(NUM_NEURONS) + 1,
   localparam int SELW        = $clog2(NUM_INPUTS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfg_valid,
   output logic                                   cfg_ready,
   input  logic [IW-1:0]                          cfg_num_inputs,
   input  logic [NW-1:0]                          cfg_num_neurons,
   input  logic [TS_W-1:0]                        cfg_num_steps,
   output logic                                   cfg_err,
   output logic                                   cfg_loaded,
   input  logic                                   start,
   input  logic                                   abort,
   output logic                                   busy,
   output logic                                   done,
   output logic [TS_W-1:0]                        step_cnt,
   input  logic                                   syn_valid,
   input  logic [NUM_SYNAPSE-1:0]                 syn_out,
   input  logic [NUM_INPUTS-1:0]                  e_in,
   input  logic [NUM_NEURONS-1:0]                 e_out,
   output logic [NUM_SYNAPSE-1:0][SELW-1:0]       sel_ip,
   output logic [NUM_SYNAPSE-1:0]                 syn_active,
   output logic [NUM_SYNAPSE-1:0]                 e_in_map,
   output logic [NUM_SYNAPSE-1:0]                 e_out_map,
   output logic [NUM_NEURONS-1:0][NUM_SYNAPSE-1:0] resp_func,
   output logic                                   resp_valid,
   output logic [NUM_NEURONS-1:0][CNT_W-1:0]      spike_cnt
);

   localparam int OWW = $clog2(NUM_NEURONS);
   localparam int SW  = $clog2(NUM_SYNAPSE);
   // Neuron counter must hold both NUM_SYNAPSE-1 (ni=1) and any nn value
   localparam int NCW = (SW > NW) ? SW : NW;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]                             state_q, state_d;
   logic [IW-1:0]                          ni_q, ni_d;
   logic [NW-1:0]                          nn_q, nn_d;
   logic [TS_W-1:0]                        steps_q, steps_d;
   logic                                   cfg_err_q, cfg_err_d;
   logic                                   cfg_loaded_q, cfg_loaded_d;
   logic [SW-1:0]                          ld_idx_q, ld_idx_d;
   logic [SELW-1:0]                        ld_in_q, ld_in_d;
   logic [NCW-1:0]                         ld_nrn_q, ld_nrn_d;
   logic [NUM_SYNAPSE-1:0][SELW-1:0]       sel_ip_q, sel_ip_d;
   logic [NUM_SYNAPSE-1:0][OWW-1:0]        owner_q, owner_d;
   logic [NUM_SYNAPSE-1:0]                 syn_active_q, syn_active_d;
   logic [NUM_NEURONS-1:0][NUM_SYNAPSE-1:0] resp_func_q, resp_func_d;
   logic                                   resp_valid_q, resp_valid_d;
   logic [TS_W-1:0]                        step_cnt_q, step_cnt_d;

   logic                                   w_cfg_legal;
   logic                                   w_cfg_acc;
   logic                                   w_run_start;
   logic                                   w_accept;
   logic                                   w_ld_last;
   logic [NUM_NEURONS-1:0][NUM_SYNAPSE-1:0] w_resp_new;

   // Handshake qualifiers; a configuration write always wins over start
   always_comb begin
      w_cfg_legal = (cfg_num_inputs != '0) && (int'(cfg_num_inputs) <= NUM_INPUTS) &&
                    (cfg_num_neurons != '0) && (int'(cfg_num_neurons) <= NUM_NEURONS) &&
                    ((int'(cfg_num_inputs) * int'(cfg_num_neurons)) <= NUM_SYNAPSE) &&
                    (cfg_num_steps != '0);
      w_cfg_acc   = (state_q == S_IDLE) && cfg_valid && w_cfg_legal;
      w_run_start = (state_q == S_IDLE) && start && cfg_loaded_q && !cfg_valid;
      w_accept    = (state_q == S_RUN) && syn_valid && !abort;
      w_ld_last   = (ld_idx_q == SW'(NUM_SYNAPSE - 1));
   end

   // Gate the fire vector by mapped synapses owned by each neuron
   always_comb begin
      w_resp_new = '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         for (int m = 0; m < NUM_SYNAPSE; m++) begin
            w_resp_new[n][m] = syn_out[m] & syn_active_q[m] & (owner_q[m] == OWW'(n));
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_cfg_acc)        state_d = S_LOAD;
            else if (w_run_start) state_d = S_RUN;
         end
         S_LOAD: if (w_ld_last) state_d = S_IDLE;
         S_RUN: begin
            if (abort) state_d = S_IDLE;
            else if (syn_valid && (step_cnt_q == steps_q - TS_W'(1))) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      cfg_ready = (state_q == S_IDLE);
      busy      = (state_q == S_LOAD) || (state_q == S_RUN);
      done      = (state_q == S_DONE);
   end

   // Datapath next values: config latch, sequential map build, run capture
   always_comb begin
      ni_d         = ni_q;
      nn_d         = nn_q;
      steps_d      = steps_q;
      cfg_err_d    = cfg_err_q;
      cfg_loaded_d = cfg_loaded_q;
      ld_idx_d     = ld_idx_q;
      ld_in_d      = ld_in_q;
      ld_nrn_d     = ld_nrn_q;
      sel_ip_d     = sel_ip_q;
      owner_d      = owner_q;
      syn_active_d = syn_active_q;
      resp_func_d  = resp_func_q;
      resp_valid_d = w_accept;
      step_cnt_d   = step_cnt_q;

      if ((state_q == S_IDLE) && cfg_valid) begin
         cfg_err_d = !w_cfg_legal;
         if (w_cfg_legal) begin
            ni_d         = cfg_num_inputs;
            nn_d         = cfg_num_neurons;
            steps_d      = cfg_num_steps;
            cfg_loaded_d = 1'b0;
            syn_active_d = '0;
            ld_idx_d     = '0;
            ld_in_d      = '0;
            ld_nrn_d     = '0;
         end
      end

      // Input counter wraps at ni-1; neuron counter steps on each wrap
      if (state_q == S_LOAD) begin
         sel_ip_d[ld_idx_q]     = ld_in_q;
         owner_d[ld_idx_q]      = ld_nrn_q[OWW-1:0];
         syn_active_d[ld_idx_q] = (ld_nrn_q < NCW'(nn_q));
         ld_idx_d               = ld_idx_q + SW'(1);
         if ({1'b0, ld_in_q} == (ni_q - IW'(1))) begin
            ld_in_d  = '0;
            ld_nrn_d = ld_nrn_q + NCW'(1);
         end else begin
            ld_in_d  = ld_in_q + SELW'(1);
         end
         if (w_ld_last) cfg_loaded_d = 1'b1;
      end

      if (w_run_start) step_cnt_d = '0;
      if (w_accept) begin
         resp_func_d = w_resp_new;
         step_cnt_d  = step_cnt_q + TS_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ni_q         <= '0;
         nn_q         <= '0;
         steps_q      <= '0;
         cfg_err_q    <= 1'b0;
         cfg_loaded_q <= 1'b0;
         ld_idx_q     <= '0;
         ld_in_q      <= '0;
         ld_nrn_q     <= '0;
         sel_ip_q     <= '0;
         owner_q      <= '0;
         syn_active_q <= '0;
         resp_func_q  <= '0;
         resp_valid_q <= 1'b0;
         step_cnt_q   <= '0;
      end else begin
         ni_q         <= ni_d;
         nn_q         <= nn_d;
         steps_q      <= steps_d;
         cfg_err_q    <= cfg_err_d;
         cfg_loaded_q <= cfg_loaded_d;
         ld_idx_q     <= ld_idx_d;
         ld_in_q      <= ld_in_d;
         ld_nrn_q     <= ld_nrn_d;
         sel_ip_q     <= sel_ip_d;
         owner_q      <= owner_d;
         syn_active_q <= syn_active_d;
         resp_func_q  <= resp_func_d;
         resp_valid_q <= resp_valid_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   // Per-synapse enables looked up through the registered map tables
   generate
      for (genvar m = 0; m < NUM_SYNAPSE; m++) begin : g_map
         assign e_in_map[m]  = syn_active_q[m] & e_in[sel_ip_q[m]];
         assign e_out_map[m] = syn_active_q[m] & e_out[owner_q[m]];
      end
   endgenerate

   assign cfg_err    = cfg_err_q;
   assign cfg_loaded = cfg_loaded_q;
   assign step_cnt   = step_cnt_q;
   assign sel_ip     = sel_ip_q;
   assign syn_active = syn_active_q;
   assign resp_func  = resp_func_q;
   assign resp_valid = resp_valid_q;

`ifdef NEURO_SPIKE_COUNT_EN
   logic [NUM_NEURONS-1:0][CNT_W-1:0] spike_cnt_q, spike_cnt_d;

   // Saturating count of timesteps in which each neuron responded
   always_comb begin
      spike_cnt_d = spike_cnt_q;
      if (w_run_start) begin
         spike_cnt_d = '0;
      end else if (w_accept) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            if ((|w_resp_new[n]) && (spike_cnt_q[n] != {CNT_W{1'b1}}))
               spike_cnt_d[n] = spike_cnt_q[n] + CNT_W'(1);
         end
      end
   end

   // Spike counter registers
   always_ff @(posedge clk) begin
      if (rst) spike_cnt_q <= '0;
      else     spike_cnt_q <= spike_cnt_d;
   end

   assign spike_cnt = spike_cnt_q;
`else
   assign spike_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuro_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuro_cfg_sequencer
// Description : Randomised self-checking bench for neuro_cfg_sequencer with
//               an arithmetic reference model (m%ni, m/ni, m<ni*nn).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuro_cfg_sequencer;
   localparam int NI_MAX = 4;
   localparam int NS     = 16;
   localparam int NN_MAX = 4;
   localparam int TS_W   = 8;
   localparam int CNT_W  = 2;
   localparam int IW     = $clog2(NI_MAX) + 1;
   localparam int NW     = $clog2(NN_MAX) + 1;
   localparam int SELW   = $clog2(NI_MAX);
`ifdef NEURO_SPIKE_COUNT_EN
   localparam bit SPK_EN = 1'b1;
`else
   localparam bit SPK_EN = 1'b0;
`endif

   logic                               clk = 1'b0;
   logic                               rst, cfg_valid, start, abort, syn_valid;
   logic                               cfg_ready, cfg_err, cfg_loaded, busy, done, resp_valid;
   logic [IW-1:0]                      cfg_num_inputs;
   logic [NW-1:0]                      cfg_num_neurons;
   logic [TS_W-1:0]                    cfg_num_steps, step_cnt;
   logic [NS-1:0]                      syn_out, syn_active, e_in_map, e_out_map;
   logic [NI_MAX-1:0]                  e_in;
   logic [NN_MAX-1:0]                  e_out;
   logic [NS-1:0][SELW-1:0]            sel_ip;
   logic [NN_MAX-1:0][NS-1:0]          resp_func;
   logic [NN_MAX-1:0][CNT_W-1:0]       spike_cnt;

   neuro_cfg_sequencer #(
      .NUM_INPUTS (NI_MAX), .NUM_SYNAPSE(NS), .NUM_NEURONS(NN_MAX),
      .TS_W       (TS_W),   .CNT_W      (CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
      .cfg_num_steps(cfg_num_steps), .cfg_err(cfg_err), .cfg_loaded(cfg_loaded),
      .start(start), .abort(abort), .busy(busy), .done(done), .step_cnt(step_cnt),
      .syn_valid(syn_valid), .syn_out(syn_out), .e_in(e_in), .e_out(e_out),
      .sel_ip(sel_ip), .syn_active(syn_active), .e_in_map(e_in_map),
      .e_out_map(e_out_map), .resp_func(resp_func), .resp_valid(resp_valid),
      .spike_cnt(spike_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int   map_ni, map_nn, m_steps, m_step;
   bit   m_loaded, m_err;
   logic [63:0] m_resp;
   int   m_spk [NN_MAX];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NS-1:0] exp_active();
      logic [NS-1:0] r = '0;
      for (int m = 0; m < NS; m++) r[m] = (m < map_ni * map_nn);
      return r;
   endfunction

   function automatic logic [63:0] exp_sel();
      logic [63:0] r = '0;
      if (map_ni != 0)
         for (int m = 0; m < NS; m++) r[m*SELW +: SELW] = SELW'(m % map_ni);
      return r;
   endfunction

   function automatic logic [NS-1:0] exp_ein_map(input logic [NI_MAX-1:0] ei);
      logic [NS-1:0] r = '0;
      for (int m = 0; m < NS; m++)
         if (m < map_ni * map_nn) r[m] = ei[m % map_ni];
      return r;
   endfunction

   function automatic logic [NS-1:0] exp_eout_map(input logic [NN_MAX-1:0] eo);
      logic [NS-1:0] r = '0;
      for (int m = 0; m < NS; m++)
         if (m < map_ni * map_nn) r[m] = eo[m / map_ni];
      return r;
   endfunction

   function automatic logic [63:0] exp_resp(input logic [NS-1:0] so);
      logic [63:0] r = '0;
      for (int n = 0; n < NN_MAX; n++)
         for (int m = 0; m < NS; m++)
            if (m < map_ni * map_nn && m / map_ni == n) r[n*NS + m] = so[m];
      return r;
   endfunction

   function automatic logic [63:0] exp_spk();
      logic [63:0] r = '0;
      if (SPK_EN)
         for (int n = 0; n < NN_MAX; n++) r[n*CNT_W +: CNT_W] = CNT_W'(m_spk[n]);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; cfg_valid = 0; start = 0; abort = 0; syn_valid = 0; syn_out = '0;
      cfg_num_inputs = '0; cfg_num_neurons = '0; cfg_num_steps = '0;
      e_in = '0; e_out = '0;
      repeat (3) tick();
      rst = 1'b0;
      map_ni = 0; map_nn = 0; m_steps = 0; m_step = 0; m_loaded = 0; m_err = 0; m_resp = '0;
      for (int n = 0; n < NN_MAX; n++) m_spk[n] = 0;
   endtask

   task automatic check_reset_state();
      check_val("rst_ready",  cfg_ready,  1);
      check_val("rst_busy",   busy,       0);
      check_val("rst_done",   done,       0);
      check_val("rst_loaded", cfg_loaded, 0);
      check_val("rst_err",    cfg_err,    0);
      check_val("rst_rvalid", resp_valid, 0);
      check_val("rst_step",   step_cnt,   0);
      check_val("rst_sel",    sel_ip,     0);
      check_val("rst_active", syn_active, 0);
      check_val("rst_resp",   resp_func,  0);
      check_val("rst_spk",    spike_cnt,  0);
   endtask

   task automatic check_map(input int iters);
      for (int i = 0; i < iters; i++) begin
         e_in = NI_MAX'($urandom); e_out = NN_MAX'($urandom);
         #1;
         check_val("map_active", syn_active, exp_active());
         check_val("map_sel",    sel_ip,     exp_sel());
         check_val("map_ein",    e_in_map,   exp_ein_map(e_in));
         check_val("map_eout",   e_out_map,  exp_eout_map(e_out));
      end
   endtask

   task automatic do_cfg(input int ni, input int nn, input int steps, input bit with_start);
      bit legal;
      int cyc;
      legal = ni >= 1 && ni <= NI_MAX && nn >= 1 && nn <= NN_MAX && ni*nn <= NS && steps != 0;
      cfg_valid = 1'b1; start = with_start;
      cfg_num_inputs = IW'(ni); cfg_num_neurons = NW'(nn); cfg_num_steps = TS_W'(steps);
      tick();
      cfg_valid = 1'b0; start = 1'b0;
      if (legal) begin
         check_val("cfg_busy",    busy,       1);
         check_val("cfg_ld_clr",  cfg_loaded, 0);
         check_val("cfg_err_clr", cfg_err,    0);
         cyc = 0;
         while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
         end
         check_val("load_cycles", cyc, NS);
         map_ni = ni; map_nn = nn; m_steps = steps; m_loaded = 1; m_err = 0;
         check_val("load_done_ld", cfg_loaded, 1);
      end else begin
         m_err = 1;
         check_val("bad_err",    cfg_err,    1);
         check_val("bad_busy",   busy,       0);
         check_val("bad_loaded", cfg_loaded, m_loaded);
         check_val("bad_active", syn_active, exp_active());
      end
   endtask

   // abort_at < 0: no abort; otherwise abort on the syn_valid after that many steps
   task automatic do_run(input int abort_at, input bit all_fire);
      bit fin, sv, ab;
      logic [NS-1:0] so;
      int cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (!m_loaded) begin
         check_val("nostart_busy", busy, 0);
         return;
      end
      m_step = 0;
      for (int n = 0; n < NN_MAX; n++) m_spk[n] = 0;
      check_val("run_busy",  busy,      1);
      check_val("run_ready", cfg_ready, 0);
      check_val("run_step0", step_cnt,  0);
      fin = 0; cyc = 0;
      while (!fin && cyc < 300) begin
         sv = ($urandom_range(0, 2) != 0);
         so = all_fire ? {NS{1'b1}} : NS'($urandom);
         ab = (abort_at >= 0) && (m_step == abort_at) && sv;
         syn_valid = sv; syn_out = so; abort = ab;
         tick();
         syn_valid = 1'b0; abort = 1'b0;
         cyc++;
         if (ab) begin
            check_val("abort_rvalid", resp_valid, 0);
            check_val("abort_done",   done,       0);
            check_val("abort_busy",   busy,       0);
            check_val("abort_step",   step_cnt,   m_step);
            fin = 1;
         end else if (sv) begin
            m_resp = exp_resp(so);
            m_step++;
            for (int n = 0; n < NN_MAX; n++)
               if (m_resp[n*NS +: NS] != '0 && m_spk[n] < (1 << CNT_W) - 1) m_spk[n]++;
            check_val("step_rvalid", resp_valid, 1);
            check_val("step_resp",   resp_func,  m_resp);
            check_val("step_cnt",    step_cnt,   m_step);
            check_val("step_done",   done,       m_step == m_steps);
            if (m_step == m_steps) fin = 1;
         end else begin
            check_val("idle_rvalid", resp_valid, 0);
            check_val("idle_resp",   resp_func,  m_resp);
            check_val("idle_done",   done,       0);
         end
         check_val("spike_cnt", spike_cnt, exp_spk());
      end
      if (!fin) check_val("run_timeout", 0, 1);
      syn_valid = 1'b1; syn_out = NS'($urandom);
      tick();
      syn_valid = 1'b0;
      check_val("post_done",   done,       0);
      check_val("post_rvalid", resp_valid, 0);
      check_val("post_ready",  cfg_ready,  1);
      check_val("post_step",   step_cnt,   m_step);
      check_val("post_resp",   resp_func,  m_resp);
      check_val("post_spk",    spike_cnt,  exp_spk());
   endtask

   initial begin
      do_reset();
      check_reset_state();

      // start before any map exists is ignored
      do_run(-1, 1'b0);

      // full map: sel_ip=m%4, owner=m/4, all synapses active
      do_cfg(4, 4, 3, 1'b0);
      check_val("full_active", syn_active, 16'hFFFF);
      check_map(3);
      do_run(-1, 1'b1);
      check_val("full_resp", resp_func, 64'hF000_0F00_00F0_000F);
      check_val("full_step", step_cnt, 3);

      // partial map 3x2
      do_cfg(3, 2, 5, 1'b0);
      check_val("p_active", syn_active, 16'h003F);
      check_val("p_sel5",   sel_ip[5],  2);
      check_val("p_sel6",   sel_ip[6],  0);
      e_in = 4'b0010; #1;
      check_val("p_ein", e_in_map, 16'h0012);
      check_map(2);

      // illegal writes leave the map alone, a legal one clears cfg_err
      do_cfg(4, 5, 3, 1'b0);
      do_cfg(0, 2, 3, 1'b0);
      do_cfg(2, 2, 0, 1'b0);
      do_cfg(5, 1, 3, 1'b0);
      check_map(1);
      do_cfg(2, 4, 3, 1'b0);
      check_val("err_cleared", cfg_err, 0);
      check_map(2);

      // abort after one step, then a clean run
      do_run(1, 1'b0);
      do_run(-1, 1'b0);

      // saturation of spike counters
      do_cfg(4, 4, 5, 1'b0);
      do_run(-1, 1'b1);

      // configuration write beats start in the same cycle
      do_cfg(4, 2, 2, 1'b1);
      check_map(1);
      do_run(-1, 1'b0);

      // randomized configurations and runs
      for (int k = 0; k < 10; k++) begin
         do_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5), 1'b0);
         check_map(1);
         do_run(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, 1'b0);
      end

      // reset in the middle of LOAD and of RUN
      do_cfg(4, 4, 4, 1'b0);
      cfg_num_inputs = 3'd2; cfg_num_neurons = 3'd2; cfg_num_steps = 8'd2;
      cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
      repeat (5) tick();
      do_reset();
      check_reset_state();
      do_cfg(4, 4, 6, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      syn_valid = 1'b1; syn_out = 16'hFFFF; tick(); syn_valid = 1'b0;
      do_reset();
      check_reset_state();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
